// File: rtl/rpsc_ca_sequencer.sv
// Power-up/power-down sequencer for the RPSC cathode-anode supply: steps fan, G1 and CA
// on in order, monitors interlock/feedback and latches the first fault cause until acknowledged.
module rpsc_ca_sequencer #(
    parameter int FAN_SPINUP_CYC = 256,
    parameter int G1_SETTLE_CYC  = 256,
    parameter int CA_RAMP_CYC    = 3840,
    parameter int COOLDOWN_CYC   = 1920
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       alarm_ack,
    input  logic       interlock_ok,
    input  logic       fan_ok,
    input  logic       g1_ok,
    input  logic       ca_ok,
    input  logic       i_ca_high,
    input  logic       u_ca_low,
    output logic       fan_on,
    output logic       g1_en,
    output logic       ca_ps_act,
    output logic       ready,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] state,
    output logic [3:0] trip_count
);

    localparam int MAX_AB = (FAN_SPINUP_CYC > G1_SETTLE_CYC) ? FAN_SPINUP_CYC : G1_SETTLE_CYC;
    localparam int MAX_CD = (CA_RAMP_CYC > COOLDOWN_CYC) ? CA_RAMP_CYC : COOLDOWN_CYC;
    localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    // One extra count of headroom so the FAULT timer can park at COOLDOWN_CYC.
    localparam int TW     = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] FAN_LAST  = TW'(FAN_SPINUP_CYC - 1);
    localparam logic [TW-1:0] G1_LAST   = TW'(G1_SETTLE_CYC - 1);
    localparam logic [TW-1:0] CA_LAST   = TW'(CA_RAMP_CYC - 1);
    localparam logic [TW-1:0] COOL_LAST = TW'(COOLDOWN_CYC - 1);
    localparam logic [TW-1:0] COOL_END  = TW'(COOLDOWN_CYC);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FAN   = 3'd1,
        S_G1    = 3'd2,
        S_CA    = 3'd3,
        S_RUN   = 3'd4,
        S_SHUT  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_fault_code;
    logic [3:0]      r_trip_count;
    logic            r_fan_on, r_g1_en, r_ca_ps_act, r_ready, r_fault;

    state_t          w_state_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic [2:0]      w_stage_code;
    logic [2:0]      w_trip_code;
    logic            w_advance;
    logic            w_fan_nxt, w_g1_nxt, w_ca_nxt, w_ready_nxt, w_fault_nxt;
    logic [2:0]      w_code_nxt;
    logic [3:0]      w_trip_nxt;

    // State register: all outputs are registered from next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_fault_code <= 3'd0;
            r_trip_count <= 4'd0;
            r_fan_on     <= 1'b0;
            r_g1_en      <= 1'b0;
            r_ca_ps_act  <= 1'b0;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_fault_code <= w_code_nxt;
            r_trip_count <= w_trip_nxt;
            r_fan_on     <= w_fan_nxt;
            r_g1_en      <= w_g1_nxt;
            r_ca_ps_act  <= w_ca_nxt;
            r_ready      <= w_ready_nxt;
            r_fault      <= w_fault_nxt;
        end
    end

    // Per-stage health check and progress condition.
    always_comb begin
        w_stage_code = 3'd0;
        w_advance    = 1'b0;
        case (r_state)
            S_FAN: if (r_timer == FAN_LAST) begin
                if (fan_ok) w_advance = 1'b1;
                else        w_stage_code = 3'd1;
            end
            S_G1: if (r_timer == G1_LAST) begin
                if (g1_ok) w_advance = 1'b1;
                else       w_stage_code = 3'd2;
            end
            S_CA: begin
                if (ca_ok)                    w_advance = 1'b1;
                else if (r_timer == CA_LAST)  w_stage_code = 3'd3;
            end
            S_RUN: begin
                if (i_ca_high)     w_stage_code = 3'd4;
                else if (u_ca_low) w_stage_code = 3'd5;
                else if (!ca_ok)   w_stage_code = 3'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_trip_code = 3'd0;
        case (r_state)
            S_IDLE:
                if (start_req && !stop_req && interlock_ok) w_state_nxt = S_FAN;
            S_FAN, S_G1, S_CA, S_RUN: begin
                if (!interlock_ok) begin
                    w_state_nxt = S_FAULT;
                    w_trip_code = 3'd6;
                end else if (w_stage_code != 3'd0) begin
                    w_state_nxt = S_FAULT;
                    w_trip_code = w_stage_code;
                end else if (stop_req) begin
                    w_state_nxt = S_SHUT;
                end else if (w_advance) begin
                    case (r_state)
                        S_FAN:   w_state_nxt = S_G1;
                        S_G1:    w_state_nxt = S_CA;
                        default: w_state_nxt = S_RUN;
                    endcase
                end
            end
            S_SHUT:
                if (r_timer == COOL_LAST) w_state_nxt = S_IDLE;
            S_FAULT:
                if (r_timer == COOL_END && alarm_ack && interlock_ok) w_state_nxt = S_IDLE;
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, plus timer/fault bookkeeping.
    always_comb begin
        if (w_state_nxt != r_state)
            w_timer_nxt = '0;
        else if (r_state == S_FAULT && r_timer == COOL_END)
            w_timer_nxt = r_timer;
        else
            w_timer_nxt = r_timer + TW'(1);

        w_fan_nxt   = 1'b0;
        w_g1_nxt    = 1'b0;
        w_ca_nxt    = 1'b0;
        w_ready_nxt = 1'b0;
        w_fault_nxt = 1'b0;
        case (w_state_nxt)
            S_FAN:   w_fan_nxt = 1'b1;
            S_G1:    begin w_fan_nxt = 1'b1; w_g1_nxt = 1'b1; end
            S_CA:    begin w_fan_nxt = 1'b1; w_g1_nxt = 1'b1; w_ca_nxt = 1'b1; end
            S_RUN:   begin
                w_fan_nxt = 1'b1; w_g1_nxt = 1'b1; w_ca_nxt = 1'b1; w_ready_nxt = 1'b1;
            end
            S_SHUT:  w_fan_nxt = 1'b1;
            S_FAULT: begin
                w_fault_nxt = 1'b1;
                w_fan_nxt   = (w_timer_nxt < COOL_END);
            end
            default: ;
        endcase

        w_code_nxt = 3'd0;
        w_trip_nxt = r_trip_count;
        if (w_state_nxt == S_FAULT) begin
            if (r_state != S_FAULT) begin
                w_code_nxt = w_trip_code;
                if (r_trip_count != 4'd15) w_trip_nxt = r_trip_count + 4'd1;
            end else begin
                w_code_nxt = r_fault_code;
            end
        end
    end

    assign fan_on     = r_fan_on;
    assign g1_en      = r_g1_en;
    assign ca_ps_act  = r_ca_ps_act;
    assign ready      = r_ready;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign state      = r_state;
    assign trip_count = r_trip_count;

endmodule

// File: tb/tb_rpsc_ca_sequencer.sv
// Directed bench for rpsc_ca_sequencer with shortened stage timings (4/4/8/6).
module tb_rpsc_ca_sequencer;

    logic       clk = 1'b0;
    logic       reset, start_req, stop_req, alarm_ack, interlock_ok;
    logic       fan_ok, g1_ok, ca_ok, i_ca_high, u_ca_low;
    logic       fan_on, g1_en, ca_ps_act, ready, fault;
    logic [2:0] fault_code, state;
    logic [3:0] trip_count;

    int total = 0;
    int bad   = 0;

    rpsc_ca_sequencer #(
        .FAN_SPINUP_CYC(4),
        .G1_SETTLE_CYC (4),
        .CA_RAMP_CYC   (8),
        .COOLDOWN_CYC  (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_req   (start_req),
        .stop_req    (stop_req),
        .alarm_ack   (alarm_ack),
        .interlock_ok(interlock_ok),
        .fan_ok      (fan_ok),
        .g1_ok       (g1_ok),
        .ca_ok       (ca_ok),
        .i_ca_high   (i_ca_high),
        .u_ca_low    (u_ca_low),
        .fan_on      (fan_on),
        .g1_en       (g1_en),
        .ca_ps_act   (ca_ps_act),
        .ready       (ready),
        .fault       (fault),
        .fault_code  (fault_code),
        .state       (state),
        .trip_count  (trip_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Packs {fan_on,g1_en,ca_ps_act,ready,fault} for compact checks.
    function automatic logic [7:0] outs();
        return {3'b000, fan_on, g1_en, ca_ps_act, ready, fault};
    endfunction

    // From IDLE: start, pass FAN_START and G1_START; returns at CA_RAMP timer 0.
    task automatic to_ca_ramp();
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        repeat (8) step();
    endtask

    // In FAULT from timer 0: finish cooldown then acknowledge.
    task automatic clear_fault();
        repeat (6) step();
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_req = 1'b0; stop_req = 1'b0; alarm_ack = 1'b0;
        interlock_ok = 1'b1; fan_ok = 1'b1; g1_ok = 1'b1; ca_ok = 1'b0;
        i_ca_high = 1'b0; u_ca_low = 1'b0;
        #2;
        step();
        chk("rst_state", state, 0);
        chk("rst_outs", outs(), 0);
        chk("rst_code", fault_code, 0);
        chk("rst_trips", trip_count, 0);
        reset = 1'b0;

        // 1. Nominal power-up.
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("nom_fan_state", state, 1);
            chk("nom_fan_outs", outs(), 8'b10000);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("nom_g1_state", state, 2);
            chk("nom_g1_outs", outs(), 8'b11000);
            step();
        end
        chk("nom_ca1", state, 3);
        chk("nom_ca_outs", outs(), 8'b11100);
        step();
        chk("nom_ca2", state, 3);
        step();
        chk("nom_ca3", state, 3);
        ca_ok = 1'b1;
        step();
        chk("nom_run_state", state, 4);
        chk("nom_run_outs", outs(), 8'b11110);

        // 2. Orderly stop.
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("stop_state", state, 5);
            chk("stop_outs", outs(), 8'b10000);
            step();
        end
        chk("stop_idle", state, 0);
        chk("stop_idle_outs", outs(), 0);

        // 3. Fan timeout.
        fan_ok = 1'b0;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        repeat (3) step();
        chk("fan_t3_state", state, 1);
        step();
        chk("fan_fault_state", state, 6);
        chk("fan_fault_code", fault_code, 1);
        chk("fan_trips", trip_count, 1);
        fan_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            alarm_ack = (i == 2);
            chk("fan_cool_outs", outs(), 8'b10001);
            chk("fan_cool_state", state, 6);
            step();
        end
        alarm_ack = 1'b0;
        chk("fan_cooled_outs", outs(), 8'b00001);
        step();
        chk("fan_ack_forgotten", state, 6);
        chk("fan_code_held", fault_code, 1);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("fan_clr_state", state, 0);
        chk("fan_clr_fault", fault, 0);
        chk("fan_clr_code", fault_code, 0);

        // 4. Interlock beats overcurrent in RUN.
        ca_ok = 1'b1;
        to_ca_ramp();
        step();
        chk("ilk_run", state, 4);
        interlock_ok = 1'b0;
        i_ca_high = 1'b1;
        step();
        chk("ilk_state", state, 6);
        chk("ilk_code", fault_code, 6);
        chk("ilk_ca_off", ca_ps_act, 0);
        chk("ilk_trips", trip_count, 2);
        interlock_ok = 1'b1;
        i_ca_high = 1'b0;
        clear_fault();
        chk("ilk_clr", state, 0);

        // 5. CA ramp timeout, then overcurrent, then trip saturation.
        ca_ok = 1'b0;
        to_ca_ramp();
        for (int i = 0; i < 8; i++) begin
            chk("ramp_state", state, 3);
            step();
        end
        chk("ramp_fault", state, 6);
        chk("ramp_code", fault_code, 3);
        chk("ramp_trips", trip_count, 3);
        clear_fault();
        ca_ok = 1'b1;
        to_ca_ramp();
        step();
        chk("oc_run", state, 4);
        i_ca_high = 1'b1;
        step();
        chk("oc_code", fault_code, 4);
        chk("oc_trips", trip_count, 4);
        u_ca_low = 1'b1;
        ca_ok = 1'b0;
        step();
        chk("oc_code_latched", fault_code, 4);
        i_ca_high = 1'b0;
        u_ca_low = 1'b0;
        repeat (5) step();
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("oc_clr", state, 0);
        for (int i = 0; i < 12; i++) begin
            start_req = 1'b1;
            step();
            start_req = 1'b0;
            interlock_ok = 1'b0;
            step();
            interlock_ok = 1'b1;
            if (i == 10) chk("sat_15", trip_count, 15);
            clear_fault();
        end
        chk("sat_hold", trip_count, 15);
        chk("sat_idle", state, 0);

        // 6. Reset mid-CA_RAMP, then conflicting requests in IDLE.
        ca_ok = 1'b0;
        to_ca_ramp();
        step();
        chk("mid_ramp", state, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_outs", outs(), 0);
        chk("mid_rst_trips", trip_count, 0);
        start_req = 1'b1;
        stop_req = 1'b1;
        step();
        chk("both_req1", state, 0);
        step();
        chk("both_req2", state, 0);
        stop_req = 1'b0;
        step();
        chk("start_after", state, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
